// File: rtl/pulse_stretch_pkg.sv
// Shared types and defaults for the pulse stretcher.
package pulse_stretch_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      HOLD
   } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module down_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && !zero) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a single-cycle tick into a pulse of programmable width, with optional
// retrigger and a mandatory low holdoff after each pulse.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter int unsigned RETRIGGER = 0,
   parameter int unsigned HOLDOFF   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [CNT_W-1:0] width,
   output logic             level,
   output logic             busy,
   output logic             done,
   output logic             missed
);

   if (64'(HOLDOFF) > (64'd1 << CNT_W)) begin : g_holdoff_check
      $error("pulse_stretch: HOLDOFF must not exceed 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

   state_e           state_q, state_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic             width_nz;
   logic             level_q, level_d;
   logic             done_q, done_d;
   logic             missed_q, missed_d;

   assign width_nz = (width != '0);

   down_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         level_q  <= 1'b0;
         done_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         done_q   <= done_d;
         missed_q <= missed_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick && width_nz) begin
               state_d      = HIGH;
               cnt_load     = 1'b1;
               cnt_load_val = width - CNT_W'(1);
            end
         end
         HIGH: begin
            // A retrigger wins over the end of the pulse so there is no gap.
            if ((RETRIGGER != 0) && tick && width_nz) begin
               cnt_load     = 1'b1;
               cnt_load_val = width - CNT_W'(1);
            end else if (cnt_zero) begin
               if (HOLDOFF > 0) begin
                  state_d      = HOLD;
                  cnt_load     = 1'b1;
                  cnt_load_val = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d  = (state_d == HIGH);
      done_d   = (state_q == HIGH) && (state_d != HIGH);
      missed_d = tick && ((state_q == HOLD) || ((state_q == HIGH) && (RETRIGGER == 0)));
      busy     = (state_q != IDLE);
   end

   assign level  = level_q;
   assign done   = done_q;
   assign missed = missed_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench: expected output waveforms are queued per instance before each
// scenario and popped one entry per cycle as the DUTs run.
module tb_pulse_stretch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] width = '0;
   logic        tick_s = 1'b0;
   logic [3:0]  width_s = '0;

   logic level0, busy0, done0, missed0;
   logic level1, busy1, done1, missed1;
   logic level2, busy2, done2, missed2;
   logic level3, busy3, done3, missed3;

   int total = 0;
   int bad = 0;

   typedef struct {
      string      tag;
      int         k;
      logic [3:0] v;
   } exp_t;

   exp_t exp_q[4][$];

   always #5 clk = ~clk;

   pulse_stretch u0 (
      .clk (clk), .reset (reset), .tick (tick), .width (width),
      .level (level0), .busy (busy0), .done (done0), .missed (missed0)
   );

   pulse_stretch #(.RETRIGGER (1)) u1 (
      .clk (clk), .reset (reset), .tick (tick), .width (width),
      .level (level1), .busy (busy1), .done (done1), .missed (missed1)
   );

   pulse_stretch #(.HOLDOFF (2)) u2 (
      .clk (clk), .reset (reset), .tick (tick), .width (width),
      .level (level2), .busy (busy2), .done (done2), .missed (missed2)
   );

   pulse_stretch #(.CNT_W (4), .RETRIGGER (1), .HOLDOFF (16)) u3 (
      .clk (clk), .reset (reset), .tick (tick_s), .width (width_s),
      .level (level3), .busy (busy3), .done (done3), .missed (missed3)
   );

   function automatic logic [3:0] obs(input int sel);
      case (sel)
         0:       return {level0, busy0, done0, missed0};
         1:       return {level1, busy1, done1, missed1};
         2:       return {level2, busy2, done2, missed2};
         default: return {level3, busy3, done3, missed3};
      endcase
   endfunction

   // Bit k of each mask is the expected value in scenario cycle k.
   task automatic sched(input string tag, input int sel, input int n, input logic [63:0] lv,
                        input logic [63:0] bz, input logic [63:0] dn, input logic [63:0] ms);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.tag = tag;
         e.k   = k;
         e.v   = {lv[k], bz[k], dn[k], ms[k]};
         exp_q[sel].push_back(e);
      end
   endtask

   task automatic chk();
      exp_t       e;
      logic [3:0] o;
      for (int s = 0; s < 4; s++) begin
         if (exp_q[s].size() > 0) begin
            e = exp_q[s].pop_front();
            o = obs(s);
            total++;
            assert (o === e.v) else begin
               bad++;
               $error("FAIL %s u%0d c%0d {level,busy,done,missed} observed=%b expected=%b",
                      e.tag, s, e.k, o, e.v);
            end
         end
      end
   endtask

   task automatic cyc(input logic t, input logic [15:0] w, input logic ts, input logic [3:0] ws);
      chk();
      tick    = t;
      width   = w;
      tick_s  = ts;
      width_s = ws;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int n, input logic [63:0] tk, input logic [15:0] w,
                        input logic [63:0] tks, input logic [3:0] ws);
      for (int i = 0; i < n; i++) begin
         cyc(tk[i], w, tks[i], ws);
      end
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #2 reset = 1'b1;
      #1;
      for (int s = 0; s < 4; s++) sched("reset", s, 1, 0, 0, 0, 0);
      chk();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int s = 0; s < 4; s++) sched("idle", s, 2, 0, 0, 0, 0);
      drive(2, 0, 0, 0, 0);

      // Basic pulse, width 3.
      sched("w3", 0, 7, 'b0001110, 'b0001110, 'b0010000, 0);
      sched("w3", 1, 7, 'b0001110, 'b0001110, 'b0010000, 0);
      sched("w3", 2, 7, 'b0001110, 'b0111110, 'b0010000, 0);
      drive(7, 'b1, 3, 0, 0);

      // Zero width is discarded.
      for (int s = 0; s < 3; s++) sched("w0", s, 4, 0, 0, 0, 0);
      drive(4, 'b1, 0, 0, 0);

      // Ticks at 0 and 2, width 4.
      sched("retrig", 0, 9, 'b11110, 'b11110, 'b100000, 'b1000);
      sched("retrig", 1, 9, 'b1111110, 'b1111110, 'b10000000, 0);
      sched("retrig", 2, 9, 'b11110, 'b1111110, 'b100000, 'b1000);
      drive(9, 'b101, 4, 0, 0);

      // Width 1, ticks at 0, 2, 4.
      sched("holdoff", 0, 9, 'b101010, 'b101010, 'b1010100, 0);
      sched("holdoff", 1, 9, 'b101010, 'b101010, 'b1010100, 0);
      sched("holdoff", 2, 9, 'b100010, 'b11101110, 'b1000100, 'b1000);
      drive(9, 'b10101, 1, 0, 0);

      // Tick on the last high cycle.
      sched("lastcyc", 0, 8, 'b110, 'b110, 'b1000, 'b1000);
      sched("lastcyc", 1, 8, 'b11110, 'b11110, 'b100000, 0);
      sched("lastcyc", 2, 8, 'b110, 'b11110, 'b1000, 'b1000);
      drive(8, 'b101, 2, 0, 0);

      // Zero-width tick during a pulse.
      sched("w0high", 0, 8, 'b1110, 'b1110, 'b10000, 'b100);
      sched("w0high", 1, 8, 'b1110, 'b1110, 'b10000, 0);
      sched("w0high", 2, 8, 'b1110, 'b111110, 'b10000, 'b100);
      cyc(1'b1, 3, 1'b0, 0);
      cyc(1'b1, 0, 1'b0, 0);
      drive(6, 0, 0, 0, 0);

      // Max width 15 on a 4-bit counter, max holdoff 16, tick ignored in HOLD.
      sched("maxw", 3, 34, 64'h0000_FFFE, 64'hFFFF_FFFE, 64'h0001_0000, 64'h0020_0000);
      drive(34, 0, 0, 64'h0010_0001, 4'd15);

      // Reset mid-pulse, then tick in the first cycle after release.
      sched("rstmid", 0, 12, 'b000110001110, 'b000110001110, 'b001000000000, 0);
      sched("rstmid", 1, 12, 'b000110001110, 'b000110001110, 'b001000000000, 0);
      sched("rstmid", 2, 12, 'b000110001110, 'b011110001110, 'b001000000000, 0);
      sched("rstmid", 3, 12, 0, 0, 0, 0);
      cyc(1'b1, 5, 1'b0, 0);
      cyc(1'b0, 5, 1'b0, 0);
      cyc(1'b0, 5, 1'b0, 0);
      chk();
      reset = 1'b1;
      #2;
      chk();
      @(posedge clk);
      #1;
      chk();
      reset = 1'b0;
      cyc(1'b1, 2, 1'b0, 0);
      drive(5, 0, 2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width-counter bit width.
REQ-002 The module SHALL have parameter RETRIGGER, default 0; when 1, a tick during the pulse restarts the pulse.
REQ-003 The module SHALL have parameter HOLDOFF, default 0, giving the number of mandatory low cycles after each pulse.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port tick, input, 1 bit: single-cycle trigger, synchronous to clk.
REQ-007 The module SHALL have port width, input, CNT_W bits: pulse length in clk cycles, sampled on the accepted tick.
REQ-008 The module SHALL have port level, output, 1 bit: the stretched pulse.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle strobe on the first low cycle after a pulse ends.
REQ-011 The module SHALL have port missed, output, 1 bit: a one-cycle strobe, registered, the cycle after a tick is ignored.

Function
REQ-012 The state machine SHALL have states IDLE, HIGH and HOLD; level SHALL be registered and high only in HIGH.
REQ-013 In IDLE, a tick with width!=0 SHALL load the counter with width-1 and enter HIGH; level goes high the next cycle.
REQ-014 In IDLE, a tick with width==0 SHALL be discarded: no state change, no done, no missed.
REQ-015 In HIGH, a counter value of 0 SHALL exit HIGH; any other value SHALL decrement, so level stays high exactly width cycles.
REQ-016 Exiting HIGH SHALL go to HOLD when HOLDOFF>0 (counter loaded HOLDOFF-1), and to IDLE otherwise.
REQ-017 HOLD SHALL decrement to 0 and then go to IDLE, giving exactly HOLDOFF low, busy cycles.
REQ-018 done SHALL assert for one cycle, coincident with the first cycle level is low after HIGH, regardless of HOLDOFF.
REQ-019 With RETRIGGER=1, a tick in HIGH with width!=0 SHALL reload the counter with width-1 and stay in HIGH.
REQ-020 Under REQ-019, level SHALL remain high for width cycles after the retriggering tick, with no gap.
REQ-021 A retrigger on the last HIGH cycle SHALL extend the pulse, and done SHALL NOT fire for the superseded end.
REQ-022 With RETRIGGER=0, a tick in HIGH SHALL be ignored and missed SHALL pulse.
REQ-023 A tick in HOLD SHALL be ignored and missed SHALL pulse, for any RETRIGGER value.
REQ-024 A tick with width==0 in HIGH under RETRIGGER=1 SHALL be ignored without missed.
REQ-025 With HOLDOFF=0, a tick on the first low cycle (state IDLE) SHALL be accepted, giving a one-cycle low gap.
REQ-026 width SHALL be treated as unsigned; the maximum value 2^CNT_W-1 SHALL produce exactly that many high cycles with no wrap.
REQ-027 HOLDOFF SHALL be statically limited to at most 2^CNT_W, enforced by an elaboration-time check.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, counter 0, and level, busy, done and missed all 0.
REQ-029 Reset asserted mid-pulse or mid-holdoff SHALL abort without a done strobe.
REQ-030 A tick in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-031 Package pulse_stretch_pkg SHALL hold the state enum (IDLE, HIGH, HOLD) and the default CNT_W constant.
REQ-032 The counter SHALL be a sub-module, down_counter: load, load value, decrement enable and zero flag, with asynchronous active-high reset.
REQ-033 pulse_stretch SHALL instantiate exactly one down_counter, shared between HIGH and HOLD.

Verification
REQ-034 Defaults, width=3, tick at cycle 0 -> level high in cycles 1-3, done in cycle 4, busy in cycles 1-3.
REQ-035 width=0, tick -> level, busy, done and missed stay 0.
REQ-036 RETRIGGER=1, width=4, ticks at cycles 0 and 2 -> level high in cycles 1-6, a single done in cycle 7.
REQ-037 RETRIGGER=0, width=4, ticks at cycles 0 and 2 -> level high in cycles 1-4, missed in cycle 3, done in cycle 5.
REQ-038 HOLDOFF=2, width=1, ticks at cycles 0, 2 and 4 -> pulse in cycle 1, missed in cycle 3, second pulse in cycle 5.
REQ-039 width=5, tick at cycle 0, reset asserted in cycle 3 -> all outputs 0 immediately, no done; a new tick after release is accepted.
